snn_step_scheduler: RTL

Sequences one SNN time step across the spiking datapath once SPI configuration and input spikes are loaded. On each time-step tick from the clock divider, it latches the input spikes and advances the synaptic delay lines. It then starts each layer in order, waits for that layer's done, and finally flags the output spikes valid. It sits between the SPI interface's ready flags and the layer/delay datapath, and owns step counting and error reporting.

---
 rtl/snn_step_scheduler_pkg.sv | 25 ++
 rtl/snn_step_scheduler_if.sv | 23 ++
 rtl/snn_step_scheduler_watchdog.sv | 28 ++
 rtl/snn_step_scheduler.sv | 135 +++++++++++++
 4 files changed

// File: rtl/snn_step_scheduler_pkg.sv
// Shared types and sizing helpers for the SNN time-step scheduler.
package snn_sched_pkg;

  typedef enum logic [2:0] {
    IDLE  = 3'd0,
    LATCH = 3'd1,
    SHIFT = 3'd2,
    START = 3'd3,
    WAIT  = 3'd4,
    DONE  = 3'd5
  } state_e;

  localparam int DEF_NUM_LAYERS = 2;
  localparam int DEF_MAX_WAIT   = 255;
  localparam int DEF_STEP_CNT_W = 8;

  // Bits needed to hold 0..n-1, never less than one bit.
  function automatic int idx_w(input int n);
    return (n <= 2) ? 1 : $clog2(n);
  endfunction

  localparam int DEF_LI_W = idx_w(DEF_NUM_LAYERS);
  localparam int DEF_WC_W = idx_w(DEF_MAX_WAIT);

endpackage

// File: rtl/snn_step_scheduler_if.sv
// Control handshake between the step scheduler and the spiking datapath.
interface snn_step_scheduler_if #(
  parameter int NUM_LAYERS = 2
);
  logic                  enable;
  logic                  step_tick;
  logic                  input_spike_ready;
  logic [NUM_LAYERS-1:0] layer_done;
  logic                  spike_latch_en;
  logic                  delay_shift_en;
  logic [NUM_LAYERS-1:0] layer_start;
  logic                  output_valid;

  modport master (
    input  enable, step_tick, input_spike_ready, layer_done,
    output spike_latch_en, delay_shift_en, layer_start, output_valid
  );

  modport slave (
    output enable, step_tick, input_spike_ready, layer_done,
    input  spike_latch_en, delay_shift_en, layer_start, output_valid
  );
endinterface

// File: rtl/snn_step_scheduler_watchdog.sv
// Per-layer wait counter; expired flags the last allowed WAIT cycle.
module snn_layer_watchdog #(
  parameter int MAX_WAIT = 255,
  parameter int WC_W     = 8
) (
  input  logic clk,
  input  logic reset,
  input  logic clr,
  input  logic inc,
  output logic expired
);
  logic [WC_W-1:0] wc_q, wc_d;

  // Clear has priority so a fresh layer always starts counting from zero.
  always_comb begin
    wc_d = wc_q;
    if (clr)      wc_d = '0;
    else if (inc) wc_d = wc_q + 1'b1;
  end

  // Counter register.
  always_ff @(posedge clk) begin
    if (reset) wc_q <= '0;
    else       wc_q <= wc_d;
  end

  assign expired = (wc_q == WC_W'(MAX_WAIT - 1));
endmodule

// File: rtl/snn_step_scheduler.sv
// Sequences one SNN time step: latch spikes, shift delays, run layers, flag output.
module snn_step_scheduler
  import snn_sched_pkg::*;
#(
  parameter int NUM_LAYERS = DEF_NUM_LAYERS,
  parameter int MAX_WAIT   = DEF_MAX_WAIT,
  parameter int STEP_CNT_W = DEF_STEP_CNT_W
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  clear_err,
  snn_step_scheduler_if.master  bus,
  output logic                  busy,
  output logic [STEP_CNT_W-1:0] step_count,
  output logic                  overrun,
  output logic                  timeout_err
);
  localparam int LI_W = idx_w(NUM_LAYERS);
  localparam int WC_W = idx_w(MAX_WAIT);

  state_e                state_q, state_d;
  logic [LI_W-1:0]       li_q, li_d;
  logic [STEP_CNT_W-1:0] cnt_q, cnt_d;
  logic                  ovr_q, ovr_d, tmo_q, tmo_d;
  logic                  latch_q, latch_d, shift_q, shift_d;
  logic                  valid_q, valid_d, busy_q, busy_d;
  logic [NUM_LAYERS-1:0] start_q, start_d;
  logic                  wc_clr, wc_inc, wc_expired, cur_done, tmo_set, ovr_set;

  assign cur_done = bus.layer_done[li_q];

  snn_layer_watchdog #(
    .MAX_WAIT (MAX_WAIT),
    .WC_W     (WC_W)
  ) u_watchdog (
    .clk     (clk),
    .reset   (reset),
    .clr     (wc_clr),
    .inc     (wc_inc),
    .expired (wc_expired)
  );

  // Next-state logic; outputs are decoded from the next state so the registered
  // pulses line up exactly with the state they belong to.
  always_comb begin
    state_d = state_q;
    li_d    = li_q;
    cnt_d   = cnt_q;
    wc_clr  = 1'b0;
    wc_inc  = 1'b0;
    tmo_set = 1'b0;
    case (state_q)
      IDLE: begin
        if (bus.step_tick && bus.enable && bus.input_spike_ready) begin
          state_d = LATCH;
          li_d    = '0;
        end
      end
      LATCH: state_d = SHIFT;
      SHIFT: state_d = START;
      START: begin
        wc_clr  = 1'b1;
        state_d = WAIT;
      end
      WAIT: begin
        // A done on the final allowed cycle beats the timeout.
        if (cur_done) begin
          if (li_q == LI_W'(NUM_LAYERS - 1)) begin
            state_d = DONE;
          end else begin
            li_d    = li_q + 1'b1;
            state_d = START;
          end
        end else if (wc_expired) begin
          tmo_set = 1'b1;
          state_d = IDLE;
        end else begin
          wc_inc = 1'b1;
        end
      end
      DONE: begin
        cnt_d   = cnt_q + 1'b1;
        state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase

    ovr_set = (state_q != IDLE) && bus.step_tick;
    ovr_d   = ovr_set || (ovr_q && !clear_err);
    tmo_d   = tmo_set || (tmo_q && !clear_err);

    latch_d = (state_d == LATCH);
    shift_d = (state_d == SHIFT);
    valid_d = (state_d == DONE);
    busy_d  = (state_d != IDLE);
    start_d = '0;
    if (state_d == START) start_d[li_d] = 1'b1;
  end

  // State, counters, sticky flags and registered outputs.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= IDLE;
      li_q    <= '0;
      cnt_q   <= '0;
      ovr_q   <= 1'b0;
      tmo_q   <= 1'b0;
      latch_q <= 1'b0;
      shift_q <= 1'b0;
      valid_q <= 1'b0;
      busy_q  <= 1'b0;
      start_q <= '0;
    end else begin
      state_q <= state_d;
      li_q    <= li_d;
      cnt_q   <= cnt_d;
      ovr_q   <= ovr_d;
      tmo_q   <= tmo_d;
      latch_q <= latch_d;
      shift_q <= shift_d;
      valid_q <= valid_d;
      busy_q  <= busy_d;
      start_q <= start_d;
    end
  end

  assign bus.spike_latch_en = latch_q;
  assign bus.delay_shift_en = shift_q;
  assign bus.layer_start    = start_q;
  assign bus.output_valid   = valid_q;
  assign busy               = busy_q;
  assign step_count         = cnt_q;
  assign overrun            = ovr_q;
  assign timeout_err        = tmo_q;
endmodule
